// File: rtl/unlock_lockout_controller_if.sv
// Parallel-digit handshake between keypad source, this controller and the unlocker.
// "up" faces the keypad source, "dn" faces the unlocker's p_* port.
interface unlock_lockout_controller_if #(
  parameter int N = 4
);
  logic [N-1:0] up_data;
  logic         up_valid;
  logic         up_ready;
  logic [N-1:0] dn_data;
  logic         dn_valid;
  logic         dn_ready;

  modport master (
    output up_data, up_valid, dn_ready,
    input  up_ready, dn_data, dn_valid
  );

  modport slave (
    input  up_data, up_valid, dn_ready,
    output up_ready, dn_data, dn_valid
  );
endinterface

// File: rtl/unlock_lockout_controller.sv
// Door-open / lockout policy stage behind the serial password unlocker.
// Counts consecutive failures, holds the door open or locks out for a fixed time, and gates the digit handshake.
module unlock_lockout_controller #(
  parameter int N              = 4,
  parameter int MAX_FAIL       = 3,
  parameter int OPEN_CYCLES    = 16,
  parameter int LOCKOUT_CYCLES = 64
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              unlock,
  input  logic                              pwd_incorrect,
  unlock_lockout_controller_if.slave        hs,
  output logic                              door_open,
  output logic                              lockout,
  output logic                              alarm,
  output logic [$clog2(MAX_FAIL+1)-1:0]     fail_count,
  output logic [7:0]                        lockout_events
);

  localparam int FW      = $clog2(MAX_FAIL + 1);
  localparam int MAX_CYC = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAIL - 1);
  localparam logic [FW-1:0] FAIL_FULL = FW'(MAX_FAIL);
  localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    OPEN   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t          state_r;
  logic [TW-1:0]   timer_r;
  logic            unlock_q_r;
  logic            pwd_q_r;
  logic            success_s;
  logic            failure_s;
  logic            armed_s;
  logic [N-1:0]    data_s;

  assign success_s = unlock & ~unlock_q_r;
  assign failure_s = pwd_incorrect & ~pwd_q_r;
  assign armed_s   = (state_r == ARMED);

  // Digits pass straight through; nothing is buffered, only valid/ready are masked.
  assign data_s      = hs.up_data;
  assign hs.dn_data  = data_s;
  assign hs.dn_valid = hs.up_valid & armed_s;
  assign hs.up_ready = hs.dn_ready & armed_s;

  // Policy FSM with edge detectors, hold timer, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ARMED;
      timer_r        <= {TW{1'b0}};
      unlock_q_r     <= 1'b0;
      pwd_q_r        <= 1'b0;
      door_open      <= 1'b0;
      lockout        <= 1'b0;
      alarm          <= 1'b0;
      fail_count     <= {FW{1'b0}};
      lockout_events <= 8'd0;
    end else begin
      // Edge registers track the inputs in every state so held levels never re-fire.
      unlock_q_r <= unlock;
      pwd_q_r    <= pwd_incorrect;
      case (state_r)
        ARMED: begin
          if (success_s) begin
            state_r    <= OPEN;
            timer_r    <= OPEN_LOAD;
            fail_count <= {FW{1'b0}};
            door_open  <= 1'b1;
          end else if (failure_s) begin
            if (fail_count == FAIL_LAST) begin
              state_r    <= LOCKED;
              timer_r    <= LOCK_LOAD;
              fail_count <= FAIL_FULL;
              lockout    <= 1'b1;
              alarm      <= 1'b1;
              if (lockout_events != 8'd255) begin
                lockout_events <= lockout_events + 8'd1;
              end
            end else begin
              fail_count <= fail_count + FW'(1);
            end
          end
        end
        OPEN: begin
          if (timer_r == {TW{1'b0}}) begin
            state_r   <= ARMED;
            door_open <= 1'b0;
          end else begin
            timer_r <= timer_r - TW'(1);
          end
        end
        LOCKED: begin
          if (timer_r == {TW{1'b0}}) begin
            state_r    <= ARMED;
            fail_count <= {FW{1'b0}};
            lockout    <= 1'b0;
            alarm      <= 1'b0;
          end else begin
            timer_r <= timer_r - TW'(1);
          end
        end
        default: begin
          state_r   <= ARMED;
          timer_r   <= {TW{1'b0}};
          door_open <= 1'b0;
          lockout   <= 1'b0;
          alarm     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unlock_lockout_controller.sv
// Directed + randomized bench for unlock_lockout_controller against a remaining-cycles reference model.
module tb_unlock_lockout_controller;

  localparam int N  = 4;
  localparam int MF = 3;
  localparam int OC = 4;
  localparam int LC = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       unlock = 1'b0;
  logic       pwd_incorrect = 1'b0;
  logic       door_open;
  logic       lockout;
  logic       alarm;
  logic [1:0] fail_count;
  logic [7:0] lockout_events;

  int compared = 0;
  int mismatched = 0;

  // Reference model: cycles of door-open / lockout still to come, plus counters.
  int m_open, m_lock, m_fails, m_ev;
  bit m_pu, m_pp;

  always #5 clk = ~clk;

  unlock_lockout_controller_if #(.N(N)) hs ();

  unlock_lockout_controller #(
    .N(N), .MAX_FAIL(MF), .OPEN_CYCLES(OC), .LOCKOUT_CYCLES(LC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .unlock(unlock), .pwd_incorrect(pwd_incorrect),
    .hs(hs), .door_open(door_open), .lockout(lockout), .alarm(alarm),
    .fail_count(fail_count), .lockout_events(lockout_events)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_open = 0; m_lock = 0; m_fails = 0; m_ev = 0; m_pu = 1'b0; m_pp = 1'b0;
  endtask

  task automatic tick(input bit u, input bit p, input bit v, input bit r, input logic [N-1:0] d);
    bit armed, su, sp;
    @(negedge clk);
    unlock = u; pwd_incorrect = p; hs.up_valid = v; hs.dn_ready = r; hs.up_data = d;
    #1;
    armed = (m_open == 0) && (m_lock == 0);
    check("door_open", door_open, m_open > 0);
    check("lockout", lockout, m_lock > 0);
    check("alarm", alarm, m_lock > 0);
    check("fail_count", fail_count, m_fails);
    check("lockout_events", lockout_events, m_ev);
    check("dn_valid", hs.dn_valid, v & armed);
    check("up_ready", hs.up_ready, r & armed);
    check("dn_data", hs.dn_data, d);
    su = u & ~m_pu;
    sp = p & ~m_pp;
    m_pu = u;
    m_pp = p;
    if (m_open > 0) begin
      m_open--;
    end else if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_fails = 0;
    end else if (su) begin
      m_open = OC;
      m_fails = 0;
    end else if (sp) begin
      if (m_fails + 1 == MF) begin
        m_lock = LC;
        m_fails = MF;
        if (m_ev < 255) m_ev++;
      end else begin
        m_fails++;
      end
    end
  endtask

  task automatic run(input int n, input bit u, input bit p);
    for (int i = 0; i < n; i++)
      tick(u, p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), N'($urandom));
  endtask

  task automatic fail_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      run(1, 1'b0, 1'b1);
      run(1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    model_reset();
    hs.up_valid = 1'b1; hs.dn_ready = 1'b1; hs.up_data = 4'hA;
    #7;
    check("rst_door_open", door_open, 1'b0);
    check("rst_lockout", lockout, 1'b0);
    check("rst_alarm", alarm, 1'b0);
    check("rst_fail_count", fail_count, 2'd0);
    check("rst_lockout_events", lockout_events, 8'd0);
    check("rst_dn_valid", hs.dn_valid, 1'b1);
    check("rst_up_ready", hs.up_ready, 1'b1);
    check("rst_dn_data", hs.dn_data, 4'hA);
    @(negedge clk);
    hs.up_valid = 1'b0; hs.dn_ready = 1'b0;
    rst_n = 1'b1;

    // Success pulse: door open four cycles, gating closed meanwhile.
    run(9, 1'b0, 1'b0);
    run(1, 1'b1, 1'b0);
    run(7, 1'b0, 1'b0);

    // Three failures lock out; unlock pulses during lockout are ignored.
    fail_pulses(2);
    check("fail_count_two", fail_count, 2'd2);
    run(1, 1'b0, 1'b1);
    run(2, 1'b0, 1'b0);
    run(1, 1'b1, 1'b0);
    run(1, 1'b0, 1'b0);
    run(1, 1'b1, 1'b0);
    run(8, 1'b0, 1'b0);
    check("fail_count_after_lock", fail_count, 2'd0);
    check("one_lockout_event", lockout_events, 8'd1);

    // Success clears the failure history.
    fail_pulses(2);
    run(1, 1'b1, 1'b0);
    run(6, 1'b0, 1'b0);
    fail_pulses(2);
    run(4, 1'b0, 1'b0);
    check("no_lockout_after_clear", lockout, 1'b0);

    // Simultaneous events resolve to success; a held unlock opens once.
    run(1, 1'b1, 1'b1);
    run(7, 1'b0, 1'b0);
    run(20, 1'b1, 1'b0);
    run(6, 1'b0, 1'b0);

    // Continuous valid/ready: transfers only while armed.
    for (int i = 0; i < 12; i++) tick(i == 2, 1'b0, 1'b1, 1'b1, N'($urandom));

    // Back-to-back: event in the first armed cycle after an open period.
    run(1, 1'b1, 1'b0);
    run(4, 1'b0, 1'b0);
    run(1, 1'b1, 1'b0);
    run(6, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a lockout.
    fail_pulses(3);
    run(2, 1'b0, 1'b0);
    check("lock_before_reset", lockout, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_door_open", door_open, 1'b0);
    check("async_lockout", lockout, 1'b0);
    check("async_alarm", alarm, 1'b0);
    check("async_fail_count", fail_count, 2'd0);
    check("async_lockout_events", lockout_events, 8'd0);
    unlock = 1'b0; pwd_incorrect = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run(3, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++)
      run(1, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) == 0));

    // Saturate the lockout counter.
    for (int i = 0; i < 260; i++) begin
      fail_pulses(3);
      run(LC, 1'b0, 1'b0);
    end
    check("events_saturated", lockout_events, 8'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
